knn_vote: RTL and testbench

KNN_VOTE -- requirements
Module: knn_vote

---
 rtl/knn_vote_if.sv | 28 ++
 rtl/knn_vote.sv | 162 ++++++++++++++++
 tb/tb_knn_vote.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_vote_if.sv
// Request/result bundle for the k-nearest-neighbour majority vote block.
// The master side supplies the neighbour slots and start; the slave side returns the result.
interface knn_vote_if #(
  parameter int K       = 10,
  parameter int LABEL_W = 8,
  parameter int DIST_W  = 32,
  parameter int CNT_W   = 4
);
  logic                   start;
  logic [K-1:0]           nb_valid;
  logic [K*LABEL_W-1:0]   nb_label;
  logic [K*DIST_W-1:0]    nb_dist;
  logic                   busy;
  logic                   done;
  logic [LABEL_W-1:0]     class_out;
  logic [CNT_W-1:0]       votes;
  logic                   empty;

  modport master (
    output start, nb_valid, nb_label, nb_dist,
    input  busy, done, class_out, votes, empty
  );

  modport slave (
    input  start, nb_valid, nb_label, nb_dist,
    output busy, done, class_out, votes, empty
  );
endinterface

// File: rtl/knn_vote.sv
// Majority vote over K neighbour slots: every candidate label is counted against all slots,
// ties broken by smaller minimum distance and then by smaller label. Fixed K*K+1 cycle latency.
module knn_vote #(
  parameter int K       = 10,
  parameter int LABEL_W = 8,
  parameter int DIST_W  = 32,
  parameter int CNT_W   = 4
) (
  input logic       clk,
  input logic       rst,
  input logic       soft_rst,
  knn_vote_if.slave bus
);
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t state;
  state_t state_nxt;

  logic [K-1:0]       valid_q;
  logic [LABEL_W-1:0] label_q [K];
  logic [DIST_W-1:0]  dist_q  [K];
  logic [IDX_W-1:0]   i_q;
  logic [IDX_W-1:0]   j_q;
  logic [CNT_W-1:0]   run_cnt;
  logic [DIST_W-1:0]  run_min;
  logic [CNT_W-1:0]   best_cnt;
  logic [DIST_W-1:0]  best_min;
  logic [LABEL_W-1:0] best_label;

  logic               done_q;
  logic [LABEL_W-1:0] class_q;
  logic [CNT_W-1:0]   votes_q;
  logic               empty_q;

  logic               match;
  logic               better;
  logic [LABEL_W-1:0] label_i;
  logic [CNT_W-1:0]   fin_cnt;
  logic [DIST_W-1:0]  fin_min;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          state <= IDLE;
    else if (soft_rst) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN:    if (i_q == LAST && j_q == LAST) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = done_q;
    bus.class_out = class_q;
    bus.votes     = votes_q;
    bus.empty     = empty_q;
  end

  // Running totals including the slot j currently being examined.
  always_comb begin
    label_i = label_q[i_q];
    match   = valid_q[j_q] && (label_q[j_q] == label_i);
    fin_cnt = run_cnt + CNT_W'(match);
    fin_min = (match && (dist_q[j_q] < run_min)) ? dist_q[j_q] : run_min;
    better  = valid_q[i_q] &&
              ((fin_cnt > best_cnt) ||
               ((fin_cnt == best_cnt) &&
                ((fin_min < best_min) ||
                 ((fin_min == best_min) && (label_i < best_label)))));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      for (int s = 0; s < K; s++) begin
        label_q[s] <= '0;
        dist_q[s]  <= '0;
      end
      i_q        <= '0;
      j_q        <= '0;
      run_cnt    <= '0;
      run_min    <= '0;
      best_cnt   <= '0;
      best_min   <= '0;
      best_label <= '0;
    end else if (soft_rst) begin
      valid_q    <= '0;
      for (int s = 0; s < K; s++) begin
        label_q[s] <= '0;
        dist_q[s]  <= '0;
      end
      i_q        <= '0;
      j_q        <= '0;
      run_cnt    <= '0;
      run_min    <= '0;
      best_cnt   <= '0;
      best_min   <= '0;
      best_label <= '0;
    end else if (state == IDLE && bus.start) begin
      valid_q <= bus.nb_valid;
      for (int s = 0; s < K; s++) begin
        label_q[s] <= bus.nb_label[s*LABEL_W +: LABEL_W];
        dist_q[s]  <= bus.nb_dist[s*DIST_W +: DIST_W];
      end
      i_q        <= '0;
      j_q        <= '0;
      run_cnt    <= '0;
      run_min    <= '1;
      best_cnt   <= '0;
      best_min   <= '1;
      best_label <= '0;
    end else if (state == SCAN) begin
      if (j_q == LAST) begin
        j_q     <= '0;
        i_q     <= (i_q == LAST) ? '0 : i_q + IDX_W'(1);
        run_cnt <= '0;
        run_min <= '1;
        if (better) begin
          best_cnt   <= fin_cnt;
          best_min   <= fin_min;
          best_label <= label_i;
        end
      end else begin
        j_q     <= j_q + IDX_W'(1);
        run_cnt <= fin_cnt;
        run_min <= fin_min;
      end
    end
  end

  // best_cnt stays zero only when no slot was valid, which also leaves best_label at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q  <= 1'b0;
      class_q <= '0;
      votes_q <= '0;
      empty_q <= 1'b0;
    end else if (soft_rst) begin
      done_q  <= 1'b0;
      class_q <= '0;
      votes_q <= '0;
      empty_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == COMMIT) begin
        done_q  <= 1'b1;
        class_q <= best_label;
        votes_q <= best_cnt;
        empty_q <= (best_cnt == '0);
      end
    end
  end
endmodule

// File: tb/tb_knn_vote.sv
// Randomised and directed bench for knn_vote, checked every cycle against a label-histogram
// model of the vote plus a countdown model of its fixed latency.
module tb_knn_vote;
  localparam int K       = 10;
  localparam int LABEL_W = 8;
  localparam int DIST_W  = 32;
  localparam int CNT_W   = 4;
  localparam int LAT     = K*K + 1;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic soft_rst = 1'b0;

  knn_vote_if #(.K(K), .LABEL_W(LABEL_W), .DIST_W(DIST_W), .CNT_W(CNT_W)) bus ();

  knn_vote #(.K(K), .LABEL_W(LABEL_W), .DIST_W(DIST_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .soft_rst (soft_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [K-1:0]         valid_v;
  int                   lab [K];
  longint               dst [K];
  logic [K*LABEL_W-1:0] lab_p;
  logic [K*DIST_W-1:0]  dst_p;

  int rem        = 0;
  bit exp_done   = 0;
  int exp_class  = 0;
  int exp_votes  = 0;
  bit exp_empty  = 0;
  int pend_class = 0;
  int pend_votes = 0;
  bit pend_empty = 0;
  bit cmp_en     = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Histogram per label, then pick highest count, then smallest min distance, then smallest label.
  function automatic void voteModel(input logic [K-1:0] v, input logic [K*LABEL_W-1:0] lp,
                                    input logic [K*DIST_W-1:0] dp,
                                    output int cls, output int vts, output bit emp);
    int     cnt  [int];
    longint mind [int];
    longint bm;
    int     lbl;
    longint dd;
    cls = 0; vts = 0; emp = 1; bm = 0;
    for (int s = 0; s < K; s++) begin
      if (v[s]) begin
        lbl = int'(lp[s*LABEL_W +: LABEL_W]);
        dd  = longint'(dp[s*DIST_W +: DIST_W]);
        if (!cnt.exists(lbl)) begin
          cnt[lbl]  = 0;
          mind[lbl] = dd;
        end
        cnt[lbl]++;
        if (dd < mind[lbl]) mind[lbl] = dd;
      end
    end
    foreach (cnt[l]) begin
      if (emp || cnt[l] > vts || (cnt[l] == vts && (mind[l] < bm || (mind[l] == bm && l < cls)))) begin
        cls = l; vts = cnt[l]; bm = mind[l]; emp = 0;
      end
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst || soft_rst) begin
      rem = 0; exp_done = 0; exp_class = 0; exp_votes = 0; exp_empty = 0;
    end else begin
      exp_done = 0;
      if (rem == 0) begin
        if (bus.start) begin
          voteModel(bus.nb_valid, bus.nb_label, bus.nb_dist, pend_class, pend_votes, pend_empty);
          rem = LAT;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          exp_class = pend_class; exp_votes = pend_votes; exp_empty = pend_empty; exp_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_busy",  bus.busy,      rem != 0);
      checkOutput("cyc_done",  bus.done,      exp_done);
      checkOutput("cyc_class", bus.class_out, exp_class);
      checkOutput("cyc_votes", bus.votes,     exp_votes);
      checkOutput("cyc_empty", bus.empty,     exp_empty);
    end
  end

  task automatic buildPacked();
    for (int s = 0; s < K; s++) begin
      lab_p[s*LABEL_W +: LABEL_W] = LABEL_W'(lab[s]);
      dst_p[s*DIST_W +: DIST_W]   = DIST_W'(dst[s]);
    end
  endtask

  task automatic applyStimulus();
    buildPacked();
    bus.nb_valid = valid_v;
    bus.nb_label = lab_p;
    bus.nb_dist  = dst_p;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic waitDone(output int edges, output bit seen);
    edges = 1;
    seen  = 0;
    while (!seen && edges < LAT + 30) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    checkOutput("done_seen", seen, 1);
  endtask

  task automatic runVote(input string name, input int e_class, input int e_votes, input int e_empty, input bit pin);
    int edges;
    bit seen;
    applyStimulus();
    waitDone(edges, seen);
    edges--;
    checkOutput({name, "_latency"}, edges, LAT);
    checkOutput({name, "_class"},   bus.class_out, e_class);
    checkOutput({name, "_votes"},   bus.votes,     e_votes);
    checkOutput({name, "_empty"},   bus.empty,     e_empty);
    if (pin) begin
      checkOutput({name, "_model_class"}, exp_class, e_class);
      checkOutput({name, "_model_votes"}, exp_votes, e_votes);
    end
  endtask

  task automatic randomFill(input int max_label, input bit wide_dist);
    valid_v = K'($urandom);
    for (int s = 0; s < K; s++) begin
      lab[s] = $urandom_range(0, max_label);
      dst[s] = wide_dist ? longint'($urandom) : longint'($urandom_range(0, 15));
    end
  endtask

  task automatic checkZeroOutputs(input string name);
    checkOutput({name, "_busy"},  bus.busy,      0);
    checkOutput({name, "_done"},  bus.done,      0);
    checkOutput({name, "_class"}, bus.class_out, 0);
    checkOutput({name, "_votes"}, bus.votes,     0);
    checkOutput({name, "_empty"}, bus.empty,     0);
  endtask

  initial begin
    int c, v, e;
    int edges;
    bit seen;
    int extra;
    bus.start = 1'b0;
    valid_v = '0;
    for (int s = 0; s < K; s++) begin lab[s] = 0; dst[s] = 0; end
    applyStimulusIdle: begin
      buildPacked();
      bus.nb_valid = valid_v; bus.nb_label = lab_p; bus.nb_dist = dst_p;
    end
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkZeroOutputs("reset");
    cmp_en = 1;
    rst = 1'b1;

    valid_v = '1;
    lab = '{3, 3, 3, 3, 3, 3, 3, 1, 2, 5};
    for (int s = 0; s < K; s++) dst[s] = $urandom_range(0, 1000);
    runVote("majority", 3, 7, 0, 1);

    lab = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 2};
    dst = '{40, 50, 60, 70, 80, 25, 90, 30, 45, 60};
    runVote("count_tie", 2, 5, 0, 1);

    lab = '{9, 9, 9, 9, 9, 4, 4, 4, 4, 4};
    dst = '{10, 11, 12, 13, 14, 30, 10, 31, 32, 33};
    runVote("full_tie", 4, 5, 0, 1);

    // Inputs change and start re-pulses mid-vote; only the snapshot may count.
    randomFill(3, 0);
    valid_v = '1;
    buildPacked();
    voteModel(valid_v, lab_p, dst_p, c, v, e);
    applyStimulus();
    repeat (19) @(negedge clk);
    randomFill(3, 1);
    applyStimulus();
    waitDone(edges, seen);
    checkOutput("snapshot_class", bus.class_out, c);
    checkOutput("snapshot_votes", bus.votes, v);
    extra = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    checkOutput("snapshot_extra_done", extra, 0);

    randomFill(3, 0);
    applyStimulus();
    repeat (49) @(posedge clk);
    #2 rst = 1'b0;
    #1 checkZeroOutputs("async_abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    randomFill(2, 0);
    valid_v = '1;
    buildPacked();
    voteModel(valid_v, lab_p, dst_p, c, v, e);
    runVote("after_rst", c, v, e, 0);

    randomFill(3, 0);
    applyStimulus();
    repeat (48) @(negedge clk);
    soft_rst  = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    soft_rst  = 1'b0;
    bus.start = 1'b0;
    checkZeroOutputs("soft_abort");
    randomFill(2, 0);
    valid_v = '1;
    buildPacked();
    voteModel(valid_v, lab_p, dst_p, c, v, e);
    runVote("after_soft", c, v, e, 0);

    valid_v = '0;
    runVote("no_valid", 0, 0, 1, 1);

    for (int n = 0; n < 25; n++) begin
      randomFill((n % 3 == 0) ? 255 : 3, n % 5 == 0);
      buildPacked();
      voteModel(valid_v, lab_p, dst_p, c, v, e);
      if (n % 4 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      runVote("random", c, v, e, 0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
